bp_cce_inst_fetch_queue: RTL
============================

# bp_cce_inst_fetch_queue

Parametrised CCE microcode fetch unit with an instruction RAM, a self-sequencing fetch PC and a decoupling instruction queue between fetch and decode. It replaces lock-step fetch with a queue, so decode stalls no longer force re-fetch. Mispredicts from EX redirect fetch and flush the queue. The configuration port loads or reads the ucode RAM while the CCE is in INIT.

## Interface
- inst_width_p, 48, microcode instruction width in bits
- pc_width_p, 8, PC width; RAM depth is 2^pc_width_p entries
- queue_els_p, 2, instruction queue depth; must be ≥ 2
- clk_i  in  1  clock, all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- mode_normal_i  in  1  CCE mode is normal; leaves INIT
- cfg_w_v_i  in  1  ucode write request
- cfg_r_v_i  in  1  ucode read request
- cfg_addr_i  in  pc_width_p  ucode address
- cfg_data_i  in  inst_width_p  ucode write data
- cfg_r_data_o  out  inst_width_p  ucode read data
- cfg_r_v_o  out  1  cfg_r_data_o valid
- redirect_v_i  in  1  EX mispredict: flush and refetch
- redirect_pc_i  in  pc_width_p  corrected PC
- inst_o  out  inst_width_p  head-of-queue instruction
- inst_pc_o  out  pc_width_p  PC of inst_o
- inst_v_o  out  1  head valid
- inst_yumi_i  in  1  decode consumes head; legal only when inst_v_o = 1
- parity_err_o  out  1  parity mismatch on head (macro only)

## Operation
- Fetch FSM states:
  - RESET → INIT unconditionally.
  - INIT → INIT_END when mode_normal_i = 1.
  - INIT_END → FETCH after one cycle; this cycle drains the final config write. fetch_pc is set to 0.
  - FETCH persists until reset. An illegal encoding returns to RESET.
- Config port:
  - Honoured only in RESET, INIT and INIT_END; ignored in FETCH.
  - cfg_w_v_i has priority over cfg_r_v_i when both are set.
  - A read issued in cycle t returns cfg_r_data_o with cfg_r_v_o = 1 in t+1.
- Fetch issue in FETCH (RAM is 1rw synchronous with one-cycle read latency):
  - A read is issued at fetch_pc when occupancy + inflight − inst_yumi_i < queue_els_p.
  - On issue, fetch_pc ← fetch_pc + 1, modulo 2^pc_width_p, so PC max wraps to 0.
  - inflight is the 1-bit count of reads whose data returns next cycle.
  - Returning data is enqueued together with its PC.
- Redirect (redirect_v_i = 1 in cycle t):
  - Queue is emptied and any inflight return is discarded.
  - inst_yumi_i in cycle t is ignored.
  - RAM read of redirect_pc_i is issued in cycle t, and fetch_pc ← redirect_pc_i + 1.
  - A redirect is accepted in any FETCH cycle, including back-to-back redirects.
- Enqueue and dequeue in the same cycle when full is legal; occupancy is unchanged.
- A yumi while empty is a protocol violation and is asserted in simulation.
- Reset mid-operation: the queue and the inflight read are dropped, and the FSM returns to RESET. RAM contents are retained.

## Timing
- Reset values: inst_v_o = 0, cfg_r_v_o = 0, parity_err_o = 0, fetch_pc = 0, occupancy = 0.
- inst_o and inst_pc_o are driven to 0 whenever inst_v_o = 0.
- Read issued in cycle t → enqueued at end of t+1 → visible on inst_o in t+2. There is no bypass.
- First instruction (PC 0): INIT_END is cycle t, inst_v_o = 1 in t+2.
- Redirect in cycle t: inst_v_o = 0 in t+1; the redirect target is on inst_o in t+2.
- With yumi held high every cycle, steady-state throughput is one instruction per cycle for any queue_els_p ≥ 2.

## Configuration
- BP_CCE_FETCH_PARITY_EN:
  - Defined:
    - RAM stores inst_width_p+1 bits per entry, with even parity over the instruction computed on config write.
    - The parity bit travels through the queue.
    - parity_err_o = inst_v_o & parity mismatch on the head entry.
    - cfg_r_data_o excludes the parity bit.
  - Undefined: RAM is inst_width_p wide and parity_err_o is tied to 0.

## Test plan
- Load PCs 0..3 with 0xA0..0xA3, raise mode_normal_i, hold yumi = 1 → inst_o = 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles with matching inst_pc_o 0..3, and the first valid two cycles after INIT_END.
- Hold yumi = 0 after the first valid, queue_els_p = 2 → occupancy saturates at 2 and no further reads issue. Release yumi → PCs continue in order with no gap or duplicate.
- Redirect to PC 0x40 while queue is full and yumi = 1 → next cycle inst_v_o = 0, following cycle inst_pc_o = 0x40; queued PCs are never seen.
- Fetch from PC 0xFF with pc_width_p = 8 → sequence 0xFF, 0x00, 0x01.
- Config read of address 5 in INIT → cfg_r_v_o = 1 with data 0xA5 the next cycle. A config write during FETCH → RAM unchanged, verified by a later fetch.
- With BP_CCE_FETCH_PARITY_EN, force a flipped RAM data bit at PC 2 → parity_err_o = 1 only in the cycle PC 2 is at the head.

Source files
------------

// File: rtl/bp_cce_inst_fetch_queue.sv
// CCE microcode fetch unit: ucode RAM, self-sequencing fetch PC and a decoupling
// instruction queue. Define BP_CCE_FETCH_PARITY_EN to store and check even parity.
module bp_cce_inst_fetch_queue #(
  parameter int inst_width_p = 48,
  parameter int pc_width_p   = 8,
  parameter int queue_els_p  = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    mode_normal_i,
  input  logic                    cfg_w_v_i,
  input  logic                    cfg_r_v_i,
  input  logic [pc_width_p-1:0]   cfg_addr_i,
  input  logic [inst_width_p-1:0] cfg_data_i,
  output logic [inst_width_p-1:0] cfg_r_data_o,
  output logic                    cfg_r_v_o,
  input  logic                    redirect_v_i,
  input  logic [pc_width_p-1:0]   redirect_pc_i,
  output logic [inst_width_p-1:0] inst_o,
  output logic [pc_width_p-1:0]   inst_pc_o,
  output logic                    inst_v_o,
  input  logic                    inst_yumi_i,
  output logic                    parity_err_o,
  output logic [1:0]              debug_state
);

`ifdef BP_CCE_FETCH_PARITY_EN
  localparam int ram_w_lp = inst_width_p + 1;
`else
  localparam int ram_w_lp = inst_width_p;
`endif
  localparam int ptr_w_lp = (queue_els_p > 1) ? $clog2(queue_els_p) : 1;
  localparam int cnt_w_lp = $clog2(queue_els_p + 1);

  typedef enum logic [1:0] {e_reset, e_init, e_init_end, e_fetch} state_e;

  state_e                  state_r;
  logic [pc_width_p-1:0]   fetch_pc_r;
  logic [ram_w_lp-1:0]     mem [0:(1<<pc_width_p)-1];
  logic [ram_w_lp-1:0]     ram_data_r;
  logic                    inflight_r;
  logic [pc_width_p-1:0]   inflight_pc_r;
  logic                    cfg_r_v_r;
  logic [ram_w_lp-1:0]     q_data [queue_els_p];
  logic [pc_width_p-1:0]   q_pc [queue_els_p];
  logic [ptr_w_lp-1:0]     head_r, tail_r;
  logic [cnt_w_lp-1:0]     count_r;

  logic                    cfg_en, cfg_w, cfg_r, fetching, redirect;
  logic                    enq, deq, seq_issue, init_issue, fetch_issue, ram_re;
  logic [pc_width_p-1:0]   issue_pc, ram_addr;
  logic [ram_w_lp-1:0]     ram_wdata, head_data;
  logic [cnt_w_lp:0]       used_n;

  // Handshake: inst_v_o/inst_o present the head; inst_yumi_i consumes it in the same
  // cycle and must only be raised while inst_v_o is high.
  assign cfg_en   = (state_r != e_fetch);
  assign cfg_w    = cfg_en & cfg_w_v_i;
  assign cfg_r    = cfg_en & cfg_r_v_i & ~cfg_w_v_i;
  assign fetching = (state_r == e_fetch);
  assign redirect = fetching & redirect_v_i;
  assign deq      = fetching & inst_yumi_i & ~redirect_v_i & (count_r != '0);
  assign enq      = fetching & inflight_r & ~redirect_v_i;

  // Entries committed after this cycle, counting the read already in flight.
  assign used_n    = {1'b0, count_r} + (cnt_w_lp+1)'(inflight_r) - (cnt_w_lp+1)'(deq);
  assign seq_issue = fetching & ~redirect_v_i & (used_n < (cnt_w_lp+1)'(queue_els_p));
  // INIT_END launches the PC-0 read whenever the config port leaves the RAM idle,
  // so the first instruction is visible two cycles later.
  assign init_issue  = (state_r == e_init_end) & ~cfg_w & ~cfg_r;
  assign fetch_issue = redirect | seq_issue | init_issue;
  assign issue_pc    = redirect ? redirect_pc_i : fetch_pc_r;
  assign ram_addr    = (cfg_w | cfg_r) ? cfg_addr_i : issue_pc;
  assign ram_re      = cfg_r | fetch_issue;

`ifdef BP_CCE_FETCH_PARITY_EN
  assign ram_wdata = {^cfg_data_i, cfg_data_i};
`else
  assign ram_wdata = cfg_data_i;
`endif

  always_ff @(posedge clk_i) begin
    if (cfg_w)
      mem[ram_addr] <= ram_wdata;
    else if (ram_re)
      ram_data_r <= mem[ram_addr];
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      q_data[tail_r] <= ram_data_r;
      q_pc[tail_r]   <= inflight_pc_r;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r       <= e_reset;
      fetch_pc_r    <= '0;
      inflight_r    <= 1'b0;
      inflight_pc_r <= '0;
      cfg_r_v_r     <= 1'b0;
      head_r        <= '0;
      tail_r        <= '0;
      count_r       <= '0;
    end else begin
      cfg_r_v_r     <= cfg_r;
      inflight_r    <= fetch_issue;
      inflight_pc_r <= issue_pc;
      if (fetch_issue)
        fetch_pc_r <= issue_pc + pc_width_p'(1);
      case (state_r)
        e_reset:    state_r <= e_init;
        e_init: begin
          if (mode_normal_i) begin
            state_r    <= e_init_end;
            fetch_pc_r <= '0;
          end
        end
        e_init_end: state_r <= e_fetch;
        e_fetch:    state_r <= e_fetch;
        default:    state_r <= e_reset;
      endcase
      if (redirect) begin
        head_r  <= '0;
        tail_r  <= '0;
        count_r <= '0;
      end else begin
        if (enq)
          tail_r <= (tail_r == ptr_w_lp'(queue_els_p-1)) ? '0 : tail_r + ptr_w_lp'(1);
        if (deq)
          head_r <= (head_r == ptr_w_lp'(queue_els_p-1)) ? '0 : head_r + ptr_w_lp'(1);
        count_r <= count_r + cnt_w_lp'(enq) - cnt_w_lp'(deq);
      end
    end
  end

  assign head_data    = q_data[head_r];
  assign inst_v_o     = (count_r != '0);
  assign inst_o       = inst_v_o ? head_data[inst_width_p-1:0] : '0;
  assign inst_pc_o    = inst_v_o ? q_pc[head_r] : '0;
  assign cfg_r_v_o    = cfg_r_v_r;
  assign cfg_r_data_o = cfg_r_v_r ? ram_data_r[inst_width_p-1:0] : '0;
  assign debug_state  = state_r;

`ifdef BP_CCE_FETCH_PARITY_EN
  assign parity_err_o = inst_v_o & (^head_data);
`else
  assign parity_err_o = 1'b0;
`endif

  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    inst_yumi_i |-> inst_v_o);

endmodule
